// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Purpose: Power-up reset sequencer. It waits for the PLL lock to be stable,
// then releases N_DOM reset domains one at a time in ascending index order.
// After each release it waits STAGE_DLY cycles and then for that domain's
// ready acknowledge. A missing acknowledge raises a sticky fault that only a
// software reset request or the system reset clears.
//
// Ports:
//   sys_clk     in   single clock, rising edge
//   sys_rst     in   synchronous active-high reset, highest priority
//   pll_locked  in   asynchronous PLL lock, 2-flop synchronized here
//   sw_rst_req  in   one-cycle software request to restart the sequence
//   dom_ack     in   [N_DOM] per-domain "out of reset and ready"
//   dom_rst     out  [N_DOM] active-high per-domain reset
//   seq_done    out  all domains released and acknowledged
//   seq_err     out  acknowledge timeout fault
//   err_dom     out  [3] index of the domain that timed out
//   state_o     out  [3] current FSM state code
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
   parameter int N_DOM      = 4,
   parameter int STABLE_CYC = 64,
   parameter int STAGE_DLY  = 16,
   parameter int ACK_TO     = 1024
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             pll_locked,
   input  logic             sw_rst_req,
   input  logic [N_DOM-1:0] dom_ack,
   output logic [N_DOM-1:0] dom_rst,
   output logic             seq_done,
   output logic             seq_err,
   output logic [2:0]       err_dom,
   output logic [2:0]       state_o
);

   localparam int MAX_A = (STABLE_CYC > STAGE_DLY) ? STABLE_CYC : STAGE_DLY;
   localparam int MAX_P = (MAX_A > ACK_TO) ? MAX_A : ACK_TO;
   localparam int CNT_W = $clog2(MAX_P) + 1;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DLY - 1);
   localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TO - 1);
   localparam logic [2:0]       LAST_IDX    = 3'(N_DOM - 1);

   typedef enum logic [2:0] {
      HOLD     = 3'd0,
      STABLE   = 3'd1,
      REL      = 3'd2,
      WAIT_ACK = 3'd3,
      RUN      = 3'd4,
      FAULT    = 3'd5
   } state_t;

   state_t           state_q;
   logic             lock_meta_q;
   logic             lock_sync_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [N_DOM-1:0] dom_rst_q;
   logic             seq_done_q;
   logic             seq_err_q;
   logic [2:0]       err_dom_q;

   // Widened copy so a 3-bit index can select any domain for any N_DOM.
   logic [7:0]       ack_ext;

   assign ack_ext = 8'(dom_ack);

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // Reset pattern once domain i is released: domains 0..i low, the rest high.
   function automatic logic [N_DOM-1:0] rel_mask(input logic [2:0] i);
      logic [N_DOM-1:0] m;
      m = '1;
      return m << ({1'b0, i} + 4'd1);
   endfunction

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= HOLD;
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
         cnt_q       <= '0;
         idx_q       <= '0;
         dom_rst_q   <= '1;
         seq_done_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         err_dom_q   <= '0;
      end else begin
         lock_meta_q <= pll_locked;
         lock_sync_q <= lock_meta_q;

         if (sw_rst_req) begin
            // Software restart wins over lock loss and leaves FAULT.
            // err_dom is kept as a diagnostic of the last fault.
            state_q    <= HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            dom_rst_q  <= '1;
            seq_done_q <= 1'b0;
            seq_err_q  <= 1'b0;
         end else if (!lock_sync_q && state_q != HOLD && state_q != FAULT) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            dom_rst_q  <= '1;
            seq_done_q <= 1'b0;
         end else begin
            case (state_q)
               HOLD: begin
                  cnt_q      <= '0;
                  idx_q      <= '0;
                  dom_rst_q  <= '1;
                  seq_done_q <= 1'b0;
                  if (lock_sync_q) begin
                     state_q <= STABLE;
                  end
               end

               // Lock is known high here; a low sample was handled above.
               STABLE: begin
                  if (cnt_q == STABLE_LAST) begin
                     state_q   <= REL;
                     cnt_q     <= '0;
                     idx_q     <= '0;
                     dom_rst_q <= rel_mask(3'd0);
                  end else begin
                     cnt_q <= sat_inc(cnt_q);
                  end
               end

               REL: begin
                  if (cnt_q == STAGE_LAST) begin
                     state_q <= WAIT_ACK;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= sat_inc(cnt_q);
                  end
               end

               // An ack arriving on the timeout cycle still counts as success.
               WAIT_ACK: begin
                  if (ack_ext[idx_q]) begin
                     cnt_q <= '0;
                     if (idx_q == LAST_IDX) begin
                        state_q    <= RUN;
                        dom_rst_q  <= '0;
                        seq_done_q <= 1'b1;
                     end else begin
                        state_q   <= REL;
                        idx_q     <= idx_q + 3'd1;
                        dom_rst_q <= rel_mask(idx_q + 3'd1);
                     end
                  end else if (cnt_q == ACK_LAST) begin
                     state_q   <= FAULT;
                     seq_err_q <= 1'b1;
                     err_dom_q <= idx_q;
                     dom_rst_q <= '1;
                  end else begin
                     cnt_q <= sat_inc(cnt_q);
                  end
               end

               // Acks are not monitored once the system is running.
               RUN: begin
                  dom_rst_q  <= '0;
                  seq_done_q <= 1'b1;
               end

               FAULT: begin
                  dom_rst_q  <= '1;
                  seq_done_q <= 1'b0;
                  seq_err_q  <= 1'b1;
               end

               default: begin
                  state_q    <= HOLD;
                  cnt_q      <= '0;
                  idx_q      <= '0;
                  dom_rst_q  <= '1;
                  seq_done_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign dom_rst  = dom_rst_q;
   assign seq_done = seq_done_q;
   assign seq_err  = seq_err_q;
   assign err_dom  = err_dom_q;
   assign state_o  = state_q;

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter N_DOM, default 4, number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter STABLE_CYC, default 64, cycles the PLL lock must stay high before sequencing starts (>=2).
REQ-003 SHALL have parameter STAGE_DLY, default 16, cycles between releasing one domain and sampling its ack (>=1).
REQ-004 SHALL have parameter ACK_TO, default 1024, per-domain ack timeout in cycles, counted after STAGE_DLY.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: asynchronous PLL lock, synchronized internally by 2 flops.
REQ-008 SHALL have port sw_rst_req, input, 1 bit: synchronous one-cycle software reset request.
REQ-009 SHALL have port dom_ack, input, N_DOM bits: per-domain "out of reset and ready" flag.
REQ-010 SHALL have port dom_rst, output, N_DOM bits: active-high per-domain reset.
REQ-011 SHALL have port seq_done, output, 1 bit: all domains released and acknowledged.
REQ-012 SHALL have port seq_err, output, 1 bit: ack timeout fault.
REQ-013 SHALL have port err_dom, output, 3 bits: index of the domain that timed out.
REQ-014 SHALL have port state_o, output, 3 bits: current FSM state encoding.

Function
REQ-015 FSM states SHALL be HOLD=0, STABLE=1, REL=2, WAIT_ACK=3, RUN=4, FAULT=5; all other codes recover to HOLD.
REQ-016 In HOLD: dom_rst all ones; counters cleared; go to STABLE when synced lock = 1.
REQ-017 In STABLE: count cycles with synced lock high; after STABLE_CYC consecutive high cycles go to REL with index idx=0; any low sample returns to HOLD with counter cleared.
REQ-018 In REL: deassert dom_rst[idx] on the state-entry clock edge; hold STAGE_DLY cycles, then go to WAIT_ACK.
REQ-019 In WAIT_ACK: when dom_ack[idx]=1, go to REL with idx+1, or go to RUN if idx=N_DOM-1; if ACK_TO cycles elapse without ack, go to FAULT.
REQ-020 Domains SHALL be released strictly in ascending index order; dom_rst[k] for k>idx SHALL stay 1 until reached.
REQ-021 In RUN: seq_done=1, dom_rst all zeros; dom_ack deassertion SHALL be ignored.
REQ-022 In FAULT: seq_err=1; err_dom=idx; dom_rst all ones; seq_done=0; leave only via sw_rst_req or sys_rst.
REQ-023 Synced lock low in any state other than HOLD and FAULT SHALL assert all dom_rst on the next edge and enter HOLD.
REQ-024 sw_rst_req in any state SHALL assert all dom_rst on the next edge, clear seq_err, and enter HOLD.
REQ-025 When sw_rst_req and lock loss coincide, the result SHALL be HOLD with seq_err cleared.
REQ-026 seq_done SHALL be 1 only in RUN and SHALL drop on the same edge as dom_rst reasserts.
REQ-027 Counters SHALL be sized by $clog2 of the largest parameter plus 1 and SHALL saturate, never wrap.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 sys_rst=1 SHALL force state HOLD, dom_rst all ones, seq_done=0, seq_err=0, err_dom=0, counters 0, and the lock synchronizer to 0 on the next edge.
REQ-030 sys_rst asserted mid-sequence SHALL take priority over all other inputs.

Verification
REQ-031 Lock high from cycle 0, all acks returned 3 cycles after release -> dom_rst clears bit 0, then bits 1..3 in order; seq_done=1 after 2+64+4*(16+3)-ish cycles, checked against the exact count.
REQ-032 Lock glitches low for 1 cycle during STABLE at count 40 -> return to HOLD, counter restarts; no dom_rst bit deasserts.
REQ-033 dom_ack[2] held 0 -> FAULT after 16+1024 cycles in domain 2; seq_err=1, err_dom=2, dom_rst=4'hF; a sw_rst_req pulse clears seq_err and the sequence restarts.
REQ-034 Lock loss in RUN -> next edge dom_rst=4'hF, seq_done=0, state HOLD; relock resequences fully.
REQ-035 sys_rst pulse during WAIT_ACK of domain 1 -> all outputs equal their reset values on the next edge.
REQ-036 sw_rst_req coincident with lock loss in REL -> HOLD, seq_err=0, dom_rst all ones.
